// File: rtl/car_pkg.sv
// Shared car-control definitions: manual command codes, legality check,
// and the UART receiver state encoding.
package car_pkg;

    localparam logic [7:0] CMD_STOP  = 8'h00;
    localparam logic [7:0] CMD_W     = 8'h01;
    localparam logic [7:0] CMD_A     = 8'h02;
    localparam logic [7:0] CMD_WA    = 8'h03;
    localparam logic [7:0] CMD_S     = 8'h04;
    localparam logic [7:0] CMD_AS    = 8'h06;
    localparam logic [7:0] CMD_D     = 8'h08;
    localparam logic [7:0] CMD_WD    = 8'h09;
    localparam logic [7:0] CMD_W_ALT = 8'h0A;
    localparam logic [7:0] CMD_DS    = 8'h0C;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic is_legal_cmd(input logic [7:0] b);
        case (b)
            CMD_STOP, CMD_W, CMD_A, CMD_WA, CMD_S,
            CMD_AS, CMD_D, CMD_WD, CMD_W_ALT, CMD_DS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arduino_cmd_rx_if.sv
// Arduino link bundle: raw serial input plus the validated command outputs.
interface arduino_cmd_rx_if;
    logic       uart_rx;
    logic [7:0] arduino_command;
    logic       cmd_valid;
    logic       cmd_err;
    logic       link_timeout;

    modport master (
        input  uart_rx,
        output arduino_command,
        output cmd_valid,
        output cmd_err,
        output link_timeout
    );

    modport slave (
        output uart_rx,
        input  arduino_command,
        input  cmd_valid,
        input  cmd_err,
        input  link_timeout
    );
endinterface

// File: rtl/arduino_cmd_rx_uart.sv
// 8N1 byte receiver: two-flop synchronizer, start-edge detect and
// mid-bit sampling FSM. byte_done is a combinational pulse on the stop sample.
module uart_byte_rx
    import car_pkg::*;
#(
    parameter int CPB  = 10,
    parameter int HALF = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       frame_ok
);

    localparam int CW = $clog2(CPB + 1);

    logic          s1;
    logic          rxs;
    logic          rxs_d;
    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [7:0]    shreg;
    logic [7:0]    sh_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            s1      <= uart_rx;
            rxs     <= s1;
            rxs_d   <= rxs;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_cnt;
        sh_nxt    = shreg;
        byte_done = 1'b0;
        frame_ok  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                // A held-low line after a bad stop bit never re-triggers here.
                if (rxs_d && !rxs) begin
                    state_nxt = RX_START;
                    bit_nxt   = '0;
                end
            end
            RX_START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CW'(CPB - 1)) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rxs, shreg[7:1]};
                    bit_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == CW'(CPB - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = RX_IDLE;
                    byte_done = 1'b1;
                    frame_ok  = rxs;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign byte_data = shreg;

endmodule

// File: rtl/arduino_cmd_rx.sv
// Arduino manual-command receiver: legality filter, command register and
// link watchdog that forces Stop when no legal byte arrives in time.
module arduino_cmd_rx
    import car_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int TIMEOUT_MS = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    arduino_cmd_rx_if.master  bus
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int TMO  = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int WW   = $clog2(TMO + 1);

    logic [7:0]    byte_data;
    logic          byte_done;
    logic          frame_ok;
    logic          accept;
    logic          reject;
    logic          expire;
    logic [7:0]    cmd_q;
    logic          valid_q;
    logic          err_q;
    logic          to_q;
    logic [WW-1:0] wd_cnt;

    uart_byte_rx #(
        .CPB  (CPB),
        .HALF (HALF)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (bus.uart_rx),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .frame_ok  (frame_ok)
    );

    assign accept = byte_done && frame_ok && is_legal_cmd(byte_data);
    assign reject = byte_done && !accept;
    assign expire = (wd_cnt == WW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= CMD_STOP;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            valid_q <= accept;
            err_q   <= reject;
            // A fresh accept beats an expiry landing on the same edge.
            if (accept) begin
                wd_cnt <= '0;
                to_q   <= 1'b0;
                cmd_q  <= byte_data;
            end else begin
                if (wd_cnt != WW'(TMO))
                    wd_cnt <= wd_cnt + 1'b1;
                if (expire) begin
                    to_q  <= 1'b1;
                    cmd_q <= CMD_STOP;
                end
            end
        end
    end

    assign bus.arduino_command = cmd_q;
    assign bus.cmd_valid       = valid_q;
    assign bus.cmd_err         = err_q;
    assign bus.link_timeout    = to_q;

endmodule

// File: tb/tb_arduino_cmd_rx.sv
// Scoreboard bench for arduino_cmd_rx: stimulus pushes expected events,
// a negedge monitor pops and compares each valid/err/timeout event.
module tb_arduino_cmd_rx;
    import car_pkg::*;

    localparam int CPB = 10;
    localparam int TMO = 1000;
    localparam int LAT = 98;

    typedef struct {
        int         kind;
        logic [7:0] cmd;
        logic       to;
        int         at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sbq[$];
    logic prev_to = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arduino_cmd_rx_if bus ();

    arduino_cmd_rx #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .TIMEOUT_MS (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
    endtask

    task automatic push(input int k, input logic [7:0] c, input logic t,
                        input int at);
        exp_t e;
        e.kind = k;
        e.cmd  = c;
        e.to   = t;
        e.at   = at;
        sbq.push_back(e);
    endtask

    // Call at a negedge; returns at the negedge 10 bits later, line idle.
    // kind: 0 valid, 1 err, -1 nothing expected.
    task automatic send(input logic [7:0] b, input logic stop, input int kind,
                        input logic [7:0] exp_cmd, output int n);
        n = cyc;
        if (kind >= 0)
            push(kind, exp_cmd, 1'b0, n + LAT);
        bus.uart_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            bus.uart_rx = b[i];
        end
        repeat (CPB) @(negedge clk);
        bus.uart_rx = stop;
        repeat (CPB) @(negedge clk);
        bus.uart_rx = 1'b1;
    endtask

    task automatic event_chk(input int k);
        exp_t e;
        if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)",
                     k, cyc);
        end else begin
            e = sbq.pop_front();
            check("ev_kind", k, e.kind);
            check("ev_cycle", cyc, e.at);
            check("ev_command", bus.arduino_command, e.cmd);
            check("ev_timeout", bus.link_timeout, e.to);
        end
    endtask

    always @(negedge clk) begin
        if (bus.cmd_valid)
            event_chk(0);
        if (bus.cmd_err)
            event_chk(1);
        if (bus.link_timeout && !prev_to)
            event_chk(2);
        prev_to = bus.link_timeout;
    end

    initial begin
        #500000;
        $display("FAIL time_limit: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int n0;
        bus.uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_command", bus.arduino_command, 8'h00);
        check("rst_valid", bus.cmd_valid, 1'b0);
        check("rst_err", bus.cmd_err, 1'b0);
        check("rst_timeout", bus.link_timeout, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'h01, 1'b1, 0, 8'h01, n);
        repeat (5) @(negedge clk);
        send(8'h05, 1'b1, 1, 8'h01, n);
        repeat (5) @(negedge clk);
        send(8'h08, 1'b0, 1, 8'h01, n);
        repeat (5) @(negedge clk);

        bus.uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_idle", 32'(dut.u_rx.state), 32'(RX_IDLE));
        check("glitch_cmd", bus.arduino_command, 8'h01);

        send(8'h02, 1'b1, 0, 8'h02, n);
        send(8'h09, 1'b1, 0, 8'h09, n);
        push(2, 8'h00, 1'b1, n + LAT + TMO);
        repeat (TMO + 20) @(negedge clk);
        check("to_level", bus.link_timeout, 1'b1);
        check("to_command", bus.arduino_command, 8'h00);

        send(8'h0C, 1'b1, 0, 8'h0C, n0);
        repeat (5) @(negedge clk);
        check("to_cleared", bus.link_timeout, 1'b0);

        while (cyc < n0 + TMO) @(negedge clk);
        send(8'h04, 1'b1, 0, 8'h04, n);
        repeat (3) @(negedge clk);
        check("coll_timeout", bus.link_timeout, 1'b0);
        check("coll_command", bus.arduino_command, 8'h04);

        bus.uart_rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (CPB) @(negedge clk);
            bus.uart_rx = i[0];
        end
        repeat (CPB) @(negedge clk);
        bus.uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        bus.uart_rx = 1'b1;
        #1;
        check("mid_rst_command", bus.arduino_command, 8'h00);
        check("mid_rst_valid", bus.cmd_valid, 1'b0);
        check("mid_rst_err", bus.cmd_err, 1'b0);
        check("mid_rst_timeout", bus.link_timeout, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h03, 1'b1, 0, 8'h03, n);

        repeat (50) @(negedge clk);
        check("final_command", bus.arduino_command, 8'h03);
        check("queue_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
